// File: rtl/fric_pkg.sv
// rtl/fric_pkg.sv - shared FRIc packet types, idle byte, length lookup and egress states
package fric_pkg;

    localparam logic [7:0] IDLE_BYTE   = 8'h00;
    localparam int         MAX_PKT_LEN = 4;

    typedef enum logic [3:0] {
        TYPE_WR_REQ  = 4'h1,
        TYPE_RD_REQ  = 4'h2,
        TYPE_WR_ACK  = 4'h4,
        TYPE_RD_RESP = 4'h5
    } fric_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_SEND,
        S_DROP
    } egress_state_e;

    // Zero length marks an unknown type; such headers are discarded.
    function automatic logic [2:0] pkt_len(input logic [3:0] pkt_type);
        case (pkt_type)
            TYPE_WR_REQ, TYPE_RD_RESP: pkt_len = 3'd4;
            TYPE_RD_REQ, TYPE_WR_ACK:  pkt_len = 3'd2;
            default:                   pkt_len = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/fric_ingress_fifo.sv
// rtl/fric_ingress_fifo.sv - per-port header parser, byte FIFO and complete-packet counter
module fric_ingress_fifo
    import fric_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       ovf_clr,
    input  logic [2:0] rd_adv,
    input  logic       pkt_pop,
    output logic [7:0] head,
    output logic       pkt_avail,
    output logic       pkt_done,
    output logic       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] used;
    logic [PW-1:0] free;
    logic [PW-1:0] pkt_cnt;
    logic [2:0]    rem;
    logic [2:0]    hdr_len;
    logic          dropping;
    logic          live;
    logic          is_hdr;
    logic          hdr_ok;
    logic          wr_en;
    logic          ovf_set;

    assign used = wr_ptr - rd_ptr;
    assign free = PW'(DEPTH) - used;

    always_comb begin
        hdr_len  = pkt_len(din[7:4]);
        is_hdr   = live && (rem == 3'd0) && (din != IDLE_BYTE) && (hdr_len != 3'd0);
        hdr_ok   = free >= PW'(MAX_PKT_LEN);
        wr_en    = (is_hdr && hdr_ok) || ((rem != 3'd0) && !dropping);
        ovf_set  = is_hdr && !hdr_ok;
        pkt_done = (rem == 3'd1) && !dropping;
    end

    // live stays low for the first edge after reset release so that edge's input is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live     <= 1'b0;
            rem      <= 3'd0;
            dropping <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            ovf      <= 1'b0;
        end else begin
            live <= 1'b1;
            if (is_hdr) begin
                rem      <= hdr_len - 3'd1;
                dropping <= !hdr_ok;
            end else if (rem != 3'd0) begin
                rem <= rem - 3'd1;
            end
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_ptr + {{(PW-3){1'b0}}, rd_adv};
            if (pkt_done && !pkt_pop)
                pkt_cnt <= pkt_cnt + PW'(1);
            else if (!pkt_done && pkt_pop)
                pkt_cnt <= pkt_cnt - PW'(1);
            if (ovf_set)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign pkt_avail = pkt_cnt != '0;

endmodule

// File: rtl/fric_switch_nport.sv
// rtl/fric_switch_nport.sv - N-port store-and-forward FRIc switch with round-robin shared crossbar
module fric_switch_nport
    import fric_pkg::*;
#(
    parameter int NPORTS = 8,
    parameter int DEPTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORTS*8-1:0] fric_in,
    output logic [NPORTS*8-1:0] fric_out,
    output logic [NPORTS-1:0]   ovf,
    output logic                bad_dst,
    input  logic                ovf_clr
);

    localparam int PW = $clog2(NPORTS);

    logic [7:0]        head [NPORTS];
    logic [2:0]        rd_adv [NPORTS];
    logic [NPORTS-1:0] avail;
    logic [NPORTS-1:0] done;
    logic [NPORTS-1:0] pkt_pop;

    egress_state_e     state, state_n;
    logic [PW-1:0]     cur_src, src_n;
    logic [PW-1:0]     cur_dst, dst_n;
    logic [2:0]        cur_len, len_n;
    logic [2:0]        sent, sent_n;
    logic [PW-1:0]     last_grant, lg_n;
    logic [NPORTS*8-1:0] out_n;
    logic [PW-1:0]     grant;
    logic              found;
    logic              wake;
    logic [7:0]        gh;

    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        fric_ingress_fifo #(.DEPTH(DEPTH)) u_ingress (
            .clk       (clk),
            .rst       (rst),
            .din       (fric_in[8*g +: 8]),
            .ovf_clr   (ovf_clr),
            .rd_adv    (rd_adv[g]),
            .pkt_pop   (pkt_pop[g]),
            .head      (head[g]),
            .pkt_avail (avail[g]),
            .pkt_done  (done[g]),
            .ovf       (ovf[g])
        );
    end

    // Round-robin search begins at the port after the previous grant.
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int i = 1; i <= NPORTS; i++) begin
            automatic int c = int'(last_grant) + i;
            if (c >= NPORTS)
                c = c - NPORTS;
            if (!found && avail[c]) begin
                found = 1'b1;
                grant = PW'(c);
            end
        end
    end

    assign gh   = head[grant];
    assign wake = (|avail) || (|done);

    always_comb begin
        state_n = state;
        src_n   = cur_src;
        dst_n   = cur_dst;
        len_n   = cur_len;
        sent_n  = sent;
        lg_n    = last_grant;
        out_n   = '0;
        pkt_pop = '0;
        for (int p = 0; p < NPORTS; p++)
            rd_adv[p] = 3'd0;

        case (state)
            S_IDLE: begin
                if (wake)
                    state_n = S_ARB;
            end
            S_ARB: begin
                if (found) begin
                    lg_n           = grant;
                    src_n          = grant;
                    len_n          = pkt_len(gh[7:4]);
                    pkt_pop[grant] = 1'b1;
                    rd_adv[grant]  = 3'd1;
                    if ({1'b0, gh[3:0]} >= 5'(NPORTS)) begin
                        state_n = S_DROP;
                    end else begin
                        dst_n = PW'(gh[3:0]);
                        out_n[8*int'(gh[3:0]) +: 8] = {gh[7:4], 4'(grant)};
                        sent_n  = 3'd1;
                        state_n = S_SEND;
                    end
                end else if (!wake) begin
                    state_n = S_IDLE;
                end
            end
            S_SEND: begin
                if (sent < cur_len) begin
                    out_n[8*int'(cur_dst) +: 8] = head[cur_src];
                    rd_adv[cur_src] = 3'd1;
                    sent_n = sent + 3'd1;
                end else begin
                    state_n = wake ? S_ARB : S_IDLE;
                end
            end
            S_DROP: begin
                rd_adv[cur_src] = cur_len - 3'd1;
                state_n = wake ? S_ARB : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cur_src    <= '0;
            cur_dst    <= '0;
            cur_len    <= 3'd0;
            sent       <= 3'd0;
            last_grant <= PW'(NPORTS - 1);
            fric_out   <= '0;
        end else begin
            state      <= state_n;
            cur_src    <= src_n;
            cur_dst    <= dst_n;
            cur_len    <= len_n;
            sent       <= sent_n;
            last_grant <= lg_n;
            fric_out   <= out_n;
        end
    end

    assign bad_dst = (state == S_DROP);

endmodule

// File: tb/tb_fric_switch_nport.sv
// tb/tb_fric_switch_nport.sv - directed scoreboard bench for fric_switch_nport
module tb_fric_switch_nport;

    localparam int NP = 8;
    localparam int DP = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ovf_clr = 1'b0;
    logic            bad_dst;
    logic [NP*8-1:0] fric_in = '0;
    logic [NP*8-1:0] fric_out;
    logic [NP-1:0]   ovf;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int bad_hi = 0;
    int mon_rem [NP];
    int hdr_cyc_q[$];
    logic [7:0] hdr_val_q[$];

    typedef struct {
        int         d;
        logic [7:0] b;
    } exp_t;
    exp_t exp_q[$];

    fric_switch_nport #(.NPORTS(NP), .DEPTH(DP)) dut (
        .clk      (clk),
        .rst      (rst),
        .fric_in  (fric_in),
        .fric_out (fric_out),
        .ovf      (ovf),
        .bad_dst  (bad_dst),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int flen(input logic [3:0] t);
        case (t)
            4'h1, 4'h5: return 4;
            4'h2, 4'h4: return 2;
            default:    return 0;
        endcase
    endfunction

    function automatic int find_idx(input int d);
        for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i].d == d) return i;
        return -1;
    endfunction

    function automatic logic [NP*8-1:0] lane(input int p, input logic [7:0] b);
        logic [NP*8-1:0] v;
        v = '0;
        v[8*p +: 8] = b;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int d, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int len);
        exp_t e;
        e.d = d;
        e.b = b0; exp_q.push_back(e);
        e.b = b1; exp_q.push_back(e);
        if (len == 4) begin
            e.b = b2; exp_q.push_back(e);
            e.b = b3; exp_q.push_back(e);
        end
    endtask

    task automatic drive(input logic [NP*8-1:0] v);
        fric_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        fric_in = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int busy();
        int s;
        s = 0;
        for (int d = 0; d < NP; d++) s += mon_rem[d];
        return s;
    endfunction

    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        fric_in = '0;
        while ((exp_q.size() != 0 || busy() != 0) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
        idle(4);
    endtask

    // Egress monitor: per-destination packet tracking against the expected queue.
    always @(negedge clk) begin : mon
        int nact;
        int idx;
        logic [7:0] b;
        if (!rst) begin
            for (int d = 0; d < NP; d++) mon_rem[d] = 0;
        end else begin
            if (bad_dst) bad_hi++;
            nact = 0;
            for (int d = 0; d < NP; d++)
                if (fric_out[8*d +: 8] != 8'h00 || mon_rem[d] != 0) nact++;
            if (nact > 0) chk("egress_exclusive", 64'(nact), 64'd1);
            for (int d = 0; d < NP; d++) begin
                b = fric_out[8*d +: 8];
                if (b != 8'h00 || mon_rem[d] != 0) begin
                    idx = find_idx(d);
                    total++;
                    assert (idx >= 0) else begin
                        bad++;
                        $error("FAIL unexpected_byte port=%0d got=%02h expected=none", d, b);
                    end
                    if (idx >= 0) begin
                        chk((mon_rem[d] == 0) ? "egress_hdr" : "egress_body", 64'(b), 64'(exp_q[idx].b));
                        if (mon_rem[d] == 0) begin
                            mon_rem[d] = flen(exp_q[idx].b[7:4]) - 1;
                            hdr_cyc_q.push_back(cyc);
                            hdr_val_q.push_back(b);
                        end else begin
                            mon_rem[d] = mon_rem[d] - 1;
                        end
                        exp_q.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        int last;
        int bad0;
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fric_out", 64'(fric_out), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_bad_dst", 64'(bad_dst), 64'd0);

        // Header present on the first edge after release must be ignored
        rst = 1'b1;
        drive(lane(0, 8'h21));
        idle(12);
        chk("ignore_first_edge", 64'(hdr_cyc_q.size()), 64'd0);

        // Write-req port 0 -> port 3, header latency
        hdr_cyc_q.delete(); hdr_val_q.delete();
        push_pkt(3, 8'h10, 8'h20, 8'h34, 8'h12, 4);
        drive(lane(0, 8'h13));
        drive(lane(0, 8'h20));
        drive(lane(0, 8'h34));
        last = cyc;
        drive(lane(0, 8'h12));
        drain("drain_wr_req", 50);
        chk("wr_req_hdr_count", 64'(hdr_cyc_q.size()), 64'd1);
        if (hdr_cyc_q.size() > 0) chk("wr_req_latency", 64'(hdr_cyc_q[0]), 64'(last + 2));

        // Simultaneous read-reqs on ports 1 and 2 -> port 7, one idle between
        hdr_cyc_q.delete(); hdr_val_q.delete();
        push_pkt(7, 8'h21, 8'h05, 8'h00, 8'h00, 2);
        push_pkt(7, 8'h22, 8'h05, 8'h00, 8'h00, 2);
        drive(lane(1, 8'h27) | lane(2, 8'h27));
        last = cyc;
        drive(lane(1, 8'h05) | lane(2, 8'h05));
        drain("drain_rd_req", 50);
        chk("rr_hdr_count", 64'(hdr_cyc_q.size()), 64'd2);
        if (hdr_cyc_q.size() == 2) begin
            chk("rr_first_hdr", 64'(hdr_val_q[0]), 64'h21);
            chk("rr_first_time", 64'(hdr_cyc_q[0]), 64'(last + 2));
            chk("rr_second_hdr", 64'(hdr_val_q[1]), 64'h22);
            chk("rr_second_time", 64'(hdr_cyc_q[1]), 64'(last + 5));
        end

        // Bad destination: dropped, single bad_dst pulse
        bad0 = bad_hi;
        drive(lane(4, 8'h1A));
        drive(lane(4, 8'h11));
        drive(lane(4, 8'h22));
        drive(lane(4, 8'h33));
        idle(15);
        chk("bad_dst_pulses", 64'(bad_hi - bad0), 64'd1);
        chk("bad_dst_low", 64'(bad_dst), 64'd0);

        // Unknown type discarded, next byte parsed as header
        hdr_cyc_q.delete(); hdr_val_q.delete();
        push_pkt(1, 8'h22, 8'h00, 8'h00, 8'h00, 2);
        drive(lane(2, 8'h30));
        drive(lane(2, 8'h21));
        drive(lane(2, 8'h00));
        drain("drain_bad_type", 50);
        chk("bad_type_hdr_count", 64'(hdr_cyc_q.size()), 64'd1);

        // Overflow: ports 0..3 keep egress busy while port 5 receives three packets
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 4; p++)
                push_pkt(p, {4'h1, 4'(p)}, 8'hA0 + 8'(p) + 8'(16*k), 8'hB0 + 8'(p), 8'hC0 + 8'(p), 4);
        end
        push_pkt(5, 8'h15, 8'h51, 8'h52, 8'h53, 4);
        push_pkt(5, 8'h15, 8'h61, 8'h62, 8'h63, 4);
        for (int k = 0; k < 2; k++) begin
            drive(lane(0, 8'h10) | lane(1, 8'h11) | lane(2, 8'h12) | lane(3, 8'h13));
            drive(lane(0, 8'hA0 + 8'(16*k)) | lane(1, 8'hA1 + 8'(16*k)) |
                  lane(2, 8'hA2 + 8'(16*k)) | lane(3, 8'hA3 + 8'(16*k)));
            drive(lane(0, 8'hB0) | lane(1, 8'hB1) | lane(2, 8'hB2) | lane(3, 8'hB3));
            drive(lane(0, 8'hC0) | lane(1, 8'hC1) | lane(2, 8'hC2) | lane(3, 8'hC3));
        end
        for (int k = 0; k < 3; k++) begin
            drive(lane(5, 8'h15));
            drive(lane(5, 8'h51 + 8'(16*k)));
            drive(lane(5, 8'h52 + 8'(16*k)));
            drive(lane(5, 8'h53 + 8'(16*k)));
        end
        drain("drain_overflow", 300);
        chk("ovf_port5", 64'(ovf), 64'h20);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("ovf_cleared", 64'(ovf), 64'd0);

        // Reset asserted during third egress byte
        hdr_cyc_q.delete(); hdr_val_q.delete();
        push_pkt(6, 8'h10, 8'hAA, 8'hBB, 8'hCC, 4);
        drive(lane(0, 8'h16));
        drive(lane(0, 8'hAA));
        drive(lane(0, 8'hBB));
        drive(lane(0, 8'hCC));
        n = 0;
        while (hdr_cyc_q.size() == 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid_rst_hdr_seen", 64'(hdr_cyc_q.size()), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_fric_out", 64'(fric_out), 64'd0);
        chk("mid_rst_bad_dst", 64'(bad_dst), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(20);
        chk("post_rst_quiet", 64'(fric_out), 64'd0);
        chk("post_rst_hdr_count", 64'(hdr_cyc_q.size()), 64'd1);
        chk("post_rst_ovf", 64'(ovf), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
